cpu_accel_memq: RTL and testbench
=================================

# cpu_accel_memq

Accelerator memory request queue that sits directly upstream of the CPU data-memory arbiter, on its accelerator port. It buffers accelerator read and write requests in an in-order FIFO. It issues each request to data memory only in cycles when neither the host nor the CPU is using memory. It captures 512-bit read data into a response register held until the accelerator accepts it. This removes lost accelerator accesses, which the arbiter otherwise causes by giving the accelerator lowest priority.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- AW, 16: address width.
- DW, 32: write-data width.
- RW, 512: read-data width.

Ports:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  accelerator request present.
- req_ready  out  1  queue can accept; equals !full; forced 0 while rst is high.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  AW  request address.
- req_wdata  in  DW  write data; ignored for reads.
- rsp_valid  out  1  read response held in register.
- rsp_ready  in  1  accelerator consumes the response.
- rsp_rdata  out  RW  read response data.
- mem_busy  in  1  host write or CPU access this cycle (ex_wrt_en | cpu_wrt_en | cpu_rd_en).
- mem_addr  out  AW  to the arbiter's accelerator address.
- mem_wrt_data  out  DW  to the arbiter's accelerator write data.
- mem_wrt_en  out  1  to the arbiter's accelerator write enable.
- mem_rd_data  in  RW  data-memory read bus; valid one cycle after the address is sampled.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Accept: a request is pushed when req_valid & req_ready. There is no bypass; an entry can issue no earlier than the next cycle.
- Queue order: strict FIFO. Reads and writes are never reordered.
- FSM states and transitions:
  - IDLE: if !empty & !mem_busy, issue the head and pop it.
    - A write drives mem_wrt_en=1, mem_addr and mem_wrt_data from the head, and stays in IDLE.
    - A read drives mem_addr from the head with mem_wrt_en=0, and goes to RD_WAIT.
  - RD_WAIT: capture mem_rd_data into rsp_rdata, set rsp_valid, go to RSP_HOLD. This is unconditional; mem_busy is ignored.
  - RSP_HOLD: rsp_valid stays high and rsp_rdata is stable. On rsp_ready, clear rsp_valid and go to IDLE. No issue happens in the same cycle.
- Outstanding reads: at most one outstanding read. No issue of any kind occurs in RD_WAIT or RSP_HOLD.
- Idle bus: when not issuing, mem_addr, mem_wrt_data and mem_wrt_en are driven to 0.
- Full: req_ready is low. A pop in the same cycle does not admit a push; the freed slot is visible the next cycle.
- Empty: no issue.
- Simultaneous push and pop (not full): both take effect and count is unchanged.
- Pointer wrap: pointers wrap modulo DEPTH. count distinguishes full from empty.
- Reset mid-operation: immediately clear the FIFO and drop any outstanding read. Return to IDLE.
- Reset values of outputs: req_ready 0 (1 once rst is low); rsp_valid 0; rsp_rdata 0; mem_addr 0; mem_wrt_data 0; mem_wrt_en 0; count 0.

## Timing
- Write: accepted in cycle N, issued in cycle N+1 if mem_busy is low. Each busy cycle delays it by one.
- Read: accepted in cycle N and issued in cycle I ≥ N+1. Memory samples the address at the end of I. mem_rd_data is captured at the end of I+1, and rsp_valid is high from I+2.
- Back-to-back writes: one write per cycle throughput while mem_busy stays low.
- Read throughput: at most one read per 3 cycles, plus any rsp_ready delay.
- Combinational paths: mem_* outputs are combinational from the FIFO head, FSM state and mem_busy. req_ready and rsp_* are registered.

## Structure
- Package cpu_accel_memq_pkg contains:
  - memq_state_t enum {IDLE, RD_WAIT, RSP_HOLD};
  - memq_req_t packed struct {wr, addr[AW], wdata[DW]}.
- Sub-module cpu_accel_memq_fifo is a generic synchronous FIFO of memq_req_t with push, pop, head, full, empty and count.
- The top level holds the FSM, the issue logic and the response register.

## Test plan
- Reset, then write 0x0010←0xDEADBEEF with mem_busy=0 → mem_wrt_en=1, mem_addr=0x0010, mem_wrt_data=0xDEADBEEF in the next cycle only; count returns to 0.
- Read 0x0020 with mem_rd_data=0xA5 replicated → rsp_valid rises 3 cycles after accept with rsp_rdata={64{8'hA5}}. Hold rsp_ready=0 for 5 cycles → data stays stable. Pulse rsp_ready → rsp_valid=0 next cycle.
- Hold mem_busy=1 and push 5 writes with DEPTH=4 → req_ready=0 after the 4th push and count=4. Release mem_busy → 4 consecutive mem_wrt_en cycles in push order.
- Push write A, read B, write C with mem_busy toggling 1,0,1,0 → issues in order A,B,C. C does not issue until rsp_ready is seen for B.
- Push and pop in the same cycle at count=2 → count stays 2. Run 3×DEPTH entries to exercise pointer wrap; data order is preserved.
- Assert rst during RD_WAIT → immediately rsp_valid=0, count=0, mem_wrt_en=0. After release, the previously captured data is never presented.

Source files
------------

// File: rtl/cpu_accel_memq_pkg.sv
// Shared types for the accelerator memory request queue: FSM states and the queued request record.
package cpu_accel_memq_pkg;

    localparam int MEMQ_AW = 16;
    localparam int MEMQ_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RSP_HOLD
    } memq_state_t;

    typedef struct packed {
        logic               wr;
        logic [MEMQ_AW-1:0] addr;
        logic [MEMQ_DW-1:0] wdata;
    } memq_req_t;

endpackage

// File: rtl/cpu_accel_memq_fifo.sv
// In-order synchronous FIFO of queued accelerator requests; count separates full from empty.
module cpu_accel_memq_fifo
    import cpu_accel_memq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  memq_req_t     din,
    output memq_req_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    memq_req_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage is not reset; an entry is only read after it has been written, so reset buys nothing.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/cpu_accel_memq.sv
// Accelerator request queue: issues buffered requests only in idle memory cycles and holds
// one 512-bit read response until the accelerator takes it.
module cpu_accel_memq
    import cpu_accel_memq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = MEMQ_AW,
    parameter int DW    = MEMQ_DW,
    parameter int RW    = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_wr,
    input  logic [AW-1:0]            req_addr,
    input  logic [DW-1:0]            req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RW-1:0]            rsp_rdata,
    input  logic                     mem_busy,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wrt_data,
    output logic                     mem_wrt_en,
    input  logic [RW-1:0]            mem_rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;

    memq_state_t   state;
    memq_req_t     entry;
    memq_req_t     head;
    logic          full;
    logic          empty;
    logic          push;
    logic          issue;
    logic [CW-1:0] count_next;

    assign entry = '{wr: req_wr, addr: req_addr, wdata: req_wdata};
    assign push  = req_valid & req_ready;
    // Only one read may be in flight, so nothing issues outside IDLE.
    assign issue = (state == IDLE) & ~empty & ~mem_busy;

    assign mem_addr     = issue ? head.addr : '0;
    assign mem_wrt_en   = issue & head.wr;
    assign mem_wrt_data = (issue & head.wr) ? head.wdata : '0;

    assign count_next = count + CW'(push) - CW'(issue);

    cpu_accel_memq_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (issue),
        .din   (entry),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Registered from next occupancy, so a slot freed by a pop only opens next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_ready <= 1'b0;
        else     req_ready <= (count_next != CW'(DEPTH));
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue && !head.wr) state <= RD_WAIT;
                end
                RD_WAIT: begin
                    rsp_rdata <= mem_rd_data;
                    rsp_valid <= 1'b1;
                    state     <= RSP_HOLD;
                end
                RSP_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_accel_memq.sv
// Directed bench for cpu_accel_memq: each task drives one scenario and checks hand-derived values.
module tb_cpu_accel_memq;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int RW    = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RW-1:0] rsp_rdata;
    logic          mem_busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wrt_data;
    logic          mem_wrt_en;
    logic [RW-1:0] mem_rd_data;
    logic [2:0]    count;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_accel_memq #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RW(RW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .mem_busy     (mem_busy),
        .mem_addr     (mem_addr),
        .mem_wrt_data (mem_wrt_data),
        .mem_wrt_en   (mem_wrt_en),
        .mem_rd_data  (mem_rd_data),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; mem_busy = 1'b0; mem_rd_data = '0;
        tick(); tick();
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %0h, expected 0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0h, expected 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== '0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %0h, expected 0", rsp_rdata); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d, expected 0", count); end
        n_checks++; if (mem_wrt_en !== 1'b0 || mem_addr !== '0 || mem_wrt_data !== '0) begin
            n_fail++; $display("FAIL reset_mem_bus: got en=%0h addr=%0h data=%0h, expected all 0", mem_wrt_en, mem_addr, mem_wrt_data);
        end
        rst = 1'b0;
        tick();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_req_ready: got %0h, expected 1", req_ready); end
    endtask

    task automatic test_write();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0010; req_wdata = 32'hDEAD_BEEF;
        #2;
        n_checks++; if (mem_wrt_en !== 1'b0) begin n_fail++; $display("FAIL write_no_bypass: got %0h, expected 0", mem_wrt_en); end
        tick();
        req_valid = 1'b0;
        #2;
        n_checks++; if (mem_wrt_en !== 1'b1 || mem_addr !== 16'h0010 || mem_wrt_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL write_issue: got en=%0h addr=%0h data=%0h, expected 1/0010/deadbeef", mem_wrt_en, mem_addr, mem_wrt_data);
        end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL write_count_1: got %0d, expected 1", count); end
        tick();
        #2;
        n_checks++; if (mem_wrt_en !== 1'b0 || mem_addr !== '0) begin
            n_fail++; $display("FAIL write_once: got en=%0h addr=%0h, expected 0/0", mem_wrt_en, mem_addr);
        end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL write_count_0: got %0d, expected 0", count); end
        tick();
    endtask

    task automatic test_read();
        logic [RW-1:0] good;
        logic [RW-1:0] other;
        good  = {64{8'hA5}};
        other = {64{8'h5A}};
        mem_rd_data = other;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0020; req_wdata = 32'h1111_1111;
        tick();                                   // accept
        req_valid = 1'b0;
        #2;
        n_checks++; if (mem_addr !== 16'h0020 || mem_wrt_en !== 1'b0 || mem_wrt_data !== '0) begin
            n_fail++; $display("FAIL read_issue: got addr=%0h en=%0h data=%0h, expected 0020/0/0", mem_addr, mem_wrt_en, mem_wrt_data);
        end
        tick();                                   // RD_WAIT: data only valid now
        mem_rd_data = good;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL read_early_valid: got %0h, expected 0", rsp_valid); end
        tick();
        mem_rd_data = other;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== good) begin
                n_fail++; $display("FAIL read_hold_%0d: got valid=%0h data=%0h", i, rsp_valid, rsp_rdata);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL read_consume: got %0h, expected 0", rsp_valid); end
    endtask

    task automatic test_full();
        mem_busy = 1'b1; req_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = 16'h0100 + 16'(i); req_wdata = 32'h1000 + 32'(i);
            #2;
            n_checks++; if (req_ready !== (i < 4)) begin
                n_fail++; $display("FAIL full_ready_%0d: got %0h, expected %0h", i, req_ready, (i < 4));
            end
            tick();
        end
        n_checks++; if (count !== 3'd4 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_count: got count=%0d ready=%0h, expected 4/0", count, req_ready);
        end
        // The 5th write stays offered; it can only enter once a pop has freed a slot.
        mem_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            n_checks++; if (mem_wrt_en !== 1'b1 || mem_addr !== 16'h0100 + 16'(i) || mem_wrt_data !== 32'h1000 + 32'(i)) begin
                n_fail++; $display("FAIL full_drain_%0d: got en=%0h addr=%0h data=%0h", i, mem_wrt_en, mem_addr, mem_wrt_data);
            end
            if (i == 0) begin
                n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_no_push: got %0h, expected 0", req_ready); end
            end
            if (i == 1) begin
                n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL full_slot_freed: got %0h, expected 1", req_ready); end
            end
            if (i == 2) begin
                n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_push_pop_count: got %0d, expected 3", count); end
            end
            tick();
            if (i == 1) req_valid = 1'b0;
        end
        #2;
        n_checks++; if (mem_wrt_en !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL full_empty: got en=%0h count=%0d, expected 0/0", mem_wrt_en, count);
        end
        tick();
    endtask

    task automatic test_order();
        logic [RW-1:0] bdata;
        logic busy_t [8];
        logic rr_t   [8];
        logic en_t   [8];
        logic [15:0] addr_t [8];
        logic rv_t   [8];
        bdata = {16{32'hB0B0_CAFE}};
        mem_rd_data = bdata;
        busy_t = '{1, 0, 1, 0, 1, 0, 0, 0};
        rr_t   = '{0, 0, 0, 0, 0, 0, 1, 0};
        en_t   = '{0, 1, 0, 0, 0, 0, 0, 1};
        addr_t = '{16'h0, 16'h30, 16'h0, 16'h40, 16'h0, 16'h0, 16'h0, 16'h50};
        rv_t   = '{0, 0, 0, 0, 0, 1, 1, 0};
        mem_busy = 1'b1; req_valid = 1'b1;
        req_wr = 1'b1; req_addr = 16'h0030; req_wdata = 32'hAAAA_0001; tick();
        req_wr = 1'b0; req_addr = 16'h0040; req_wdata = 32'h0;         tick();
        req_wr = 1'b1; req_addr = 16'h0050; req_wdata = 32'hCCCC_0003; tick();
        req_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            mem_busy = busy_t[c]; rsp_ready = rr_t[c];
            #2;
            n_checks++; if (mem_wrt_en !== en_t[c] || mem_addr !== addr_t[c] || rsp_valid !== rv_t[c]) begin
                n_fail++; $display("FAIL order_c%0d: got en=%0h addr=%0h rv=%0h, expected %0h/%0h/%0h",
                                   c, mem_wrt_en, mem_addr, rsp_valid, en_t[c], addr_t[c], rv_t[c]);
            end
            if (c == 1) begin
                n_checks++; if (mem_wrt_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL order_a_data: got %0h, expected aaaa0001", mem_wrt_data); end
            end
            if (c == 5) begin
                n_checks++; if (rsp_rdata !== bdata) begin n_fail++; $display("FAIL order_b_data: got %0h", rsp_rdata); end
            end
            if (c == 7) begin
                n_checks++; if (mem_wrt_data !== 32'hCCCC_0003) begin n_fail++; $display("FAIL order_c_data: got %0h, expected cccc0003", mem_wrt_data); end
            end
            tick();
        end
        mem_busy = 1'b0; rsp_ready = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        req_wr = 1'b1;
        for (int k = 0; k < 14; k++) begin
            mem_busy  = (k < 2);
            req_valid = (k < 12);
            req_addr  = 16'h0200 + 16'(k);
            req_wdata = 32'hC000_0000 + 32'(k);
            #2;
            if (k >= 2) begin
                n_checks++; if (mem_wrt_en !== 1'b1 || mem_addr !== 16'h0200 + 16'(k - 2) || mem_wrt_data !== 32'hC000_0000 + 32'(k - 2)) begin
                    n_fail++; $display("FAIL wrap_k%0d: got en=%0h addr=%0h data=%0h", k, mem_wrt_en, mem_addr, mem_wrt_data);
                end
            end
            if (k >= 2 && k <= 12) begin
                n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL wrap_count_k%0d: got %0d, expected 2", k, count); end
            end
            tick();
        end
        req_valid = 1'b0;
        #2;
        n_checks++; if (mem_wrt_en !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL wrap_drained: got en=%0h count=%0d, expected 0/0", mem_wrt_en, count);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        mem_busy = 1'b0; mem_rd_data = {16{32'h1234_5678}};
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0060; tick();
        req_wr = 1'b1; req_addr = 16'h0070; req_wdata = 32'h7777_7777; tick();
        req_valid = 1'b0;
        // Now in RD_WAIT with one write queued; reset lands before the capture edge.
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || count !== 3'd0 || mem_wrt_en !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_clear: got rv=%0h count=%0d en=%0h ready=%0h, expected 0/0/0/0", rsp_valid, count, mem_wrt_en, req_ready);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || mem_wrt_en !== 1'b0 || count !== 3'd0) begin
                n_fail++; $display("FAIL midrst_after_%0d: got rv=%0h en=%0h count=%0d data=%0h", i, rsp_valid, mem_wrt_en, count, rsp_rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_full();
        test_order();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
